multi_speed_counter: RTL and testbench

Parametrised up/down counter with a run/pause control, N selectable count speeds, saturate or wrap mode at the range ends, and a 4-digit multiplexed 7-segment readout. It is the next generation of the lab up/down counter. It runs entirely on one clock and uses tick enables instead of derived clocks. Pushbutton conditioning (debounce, one-pulse) stays outside the block; all pulse inputs are one clk cycle wide.

---
 rtl/multi_speed_counter_pkg.sv | 34 +++
 rtl/seg7_scan4.sv | 61 ++++++
 rtl/multi_speed_counter.sv | 145 ++++++++++++++
 tb/tb_multi_speed_counter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/multi_speed_counter_pkg.sv
// Shared definitions for the multi-speed up/down counter.
//   state_t     : run/pause state encoding
//   GLYPH_*     : fixed active-low segment patterns {g,f,e,d,c,b,a}
//   seg_decode  : decimal digit (0-9) to active-low segment pattern
package multi_speed_counter_pkg;

    typedef enum logic {
        PAUSE = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam logic [6:0] GLYPH_UP    = 7'b1011100;
    localparam logic [6:0] GLYPH_DOWN  = 7'b1100011;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = GLYPH_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_scan4.sv
// Four-digit multiplexed 7-segment scanner.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   glyphs      : four active-low segment patterns, index 0 = digit0
//   digit       : active-low digit select (one-hot low)
//   display     : active-low segments for the selected digit
// The digit select and the segment pattern are registered together on each
// scan step so the visible pair is always consistent.
module seg7_scan4
    import multi_speed_counter_pkg::*;
#(
    parameter int         SCAN_DIV    = 14,
    parameter logic [6:0] RESET_GLYPH = 7'b1000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0][6:0] glyphs,
    output logic [3:0]      digit,
    output logic [6:0]      display
);

    logic [SCAN_DIV-1:0] scan_reg;
    logic [3:0]          digit_reg;
    logic [3:0]          digit_next;
    logic [1:0]          sel_next;
    logic [6:0]          display_reg;
    logic                step;

    assign step = &scan_reg;

    // Rotation order digit0 -> 1 -> 2 -> 3; anything not one-hot-low restarts at digit0.
    always_comb begin
        digit_next = 4'b1110;
        sel_next   = 2'd0;
        case (digit_reg)
            4'b1110: begin digit_next = 4'b1101; sel_next = 2'd1; end
            4'b1101: begin digit_next = 4'b1011; sel_next = 2'd2; end
            4'b1011: begin digit_next = 4'b0111; sel_next = 2'd3; end
            default: begin digit_next = 4'b1110; sel_next = 2'd0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_reg    <= '0;
            digit_reg   <= 4'b1110;
            // Counter state is cleared in the same cycle, so digit0 shows its cleared glyph.
            display_reg <= RESET_GLYPH;
        end else begin
            scan_reg <= scan_reg + SCAN_DIV'(1);
            if (step) begin
                digit_reg   <= digit_next;
                display_reg <= glyphs[sel_next];
            end
        end
    end

    assign digit   = digit_reg;
    assign display = display_reg;

endmodule

// File: rtl/multi_speed_counter.sv
// Up/down counter with run/pause, selectable speed, saturate or wrap at the
// bounds, and a 4-digit multiplexed 7-segment readout (count, direction, speed).
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   en_pulse           : toggles PAUSE/COUNT
//   dir                : 0 = up, 1 = down
//   speed_up_pulse     : speed +1 (saturating)
//   speed_down_pulse   : speed -1 (saturating)
//   count, speed       : current count value and speed level
//   running            : high in COUNT
//   max, min           : count at upper / lower bound
//   wrap_pulse         : one cycle high when the count wraps (WRAP=1)
//   DIGIT, DISPLAY     : active-low digit select and segments
module multi_speed_counter
    import multi_speed_counter_pkg::*;
#(
    parameter  int MAX_COUNT = 99,
    parameter  int N_SPEED   = 3,
    parameter  int BASE_DIV  = 25,
    parameter  int SCAN_DIV  = 14,
    parameter  int WRAP      = 0,
    localparam int CNT_W     = $clog2(MAX_COUNT + 1),
    localparam int SPD_W     = (N_SPEED > 1) ? $clog2(N_SPEED) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_pulse,
    input  logic             dir,
    input  logic             speed_up_pulse,
    input  logic             speed_down_pulse,
    output logic [CNT_W-1:0] count,
    output logic [SPD_W-1:0] speed,
    output logic             running,
    output logic             max,
    output logic             min,
    output logic             wrap_pulse,
    output logic [3:0]       DIGIT,
    output logic [6:0]       DISPLAY
);

    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_COUNT);
    localparam logic [SPD_W-1:0] SPD_MAX = SPD_W'(N_SPEED - 1);

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    count_reg, count_next;
    logic [SPD_W-1:0]    speed_reg, speed_next;
    logic                wrap_pulse_reg, wrap_pulse_next;
    logic [BASE_DIV-1:0] prescaler_reg;
    logic [BASE_DIV-1:0] tick_bits;
    logic                tick;

    // Tick when the low (BASE_DIV-speed) prescaler bits are all ones; bits
    // above that window are forced to one so they do not gate the tick.
    genvar gi;
    generate
        for (gi = 0; gi < BASE_DIV; gi++) begin : g_tick
            assign tick_bits[gi] = prescaler_reg[gi] | ((gi + int'(speed_reg)) >= BASE_DIV);
        end
    endgenerate
    assign tick = &tick_bits;

    always_comb begin
        state_next      = state_reg;
        speed_next      = speed_reg;
        count_next      = count_reg;
        wrap_pulse_next = 1'b0;

        if (en_pulse) begin
            state_next = (state_reg == PAUSE) ? COUNT : PAUSE;
        end

        // Simultaneous up and down requests cancel.
        if (speed_up_pulse && !speed_down_pulse && speed_reg != SPD_MAX) begin
            speed_next = speed_reg + SPD_W'(1);
        end else if (speed_down_pulse && !speed_up_pulse && speed_reg != '0) begin
            speed_next = speed_reg - SPD_W'(1);
        end

        // Uses the registered state, so a tick coinciding with en_pulse still counts.
        if (tick && state_reg == COUNT) begin
            if (!dir) begin
                if (count_reg != MAX_VAL) begin
                    count_next = count_reg + CNT_W'(1);
                end else if (WRAP != 0) begin
                    count_next      = '0;
                    wrap_pulse_next = 1'b1;
                end
            end else begin
                if (count_reg != '0) begin
                    count_next = count_reg - CNT_W'(1);
                end else if (WRAP != 0) begin
                    count_next      = MAX_VAL;
                    wrap_pulse_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= PAUSE;
            count_reg      <= '0;
            speed_reg      <= '0;
            wrap_pulse_reg <= 1'b0;
            prescaler_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            speed_reg      <= speed_next;
            wrap_pulse_reg <= wrap_pulse_next;
            prescaler_reg  <= prescaler_reg + BASE_DIV'(1);
        end
    end

    // Display content: digit0 ones, digit1 tens, digit2 direction, digit3 speed.
    logic [31:0]     count_wide;
    logic [3:0][6:0] glyphs;

    always_comb begin
        count_wide = 32'(count_reg);
        glyphs[0]  = seg_decode(4'(count_wide % 32'd10));
        glyphs[1]  = seg_decode(4'(count_wide / 32'd10));
        glyphs[2]  = (state_reg == COUNT && dir) ? GLYPH_DOWN : GLYPH_UP;
        glyphs[3]  = seg_decode(4'(speed_reg));
    end

    seg7_scan4 #(
        .SCAN_DIV    (SCAN_DIV),
        .RESET_GLYPH (seg_decode(4'd0))
    ) u_scan (
        .clk     (clk),
        .rst     (rst),
        .glyphs  (glyphs),
        .digit   (DIGIT),
        .display (DISPLAY)
    );

    assign count      = count_reg;
    assign speed      = speed_reg;
    assign running    = (state_reg == COUNT);
    assign max        = (count_reg == MAX_VAL);
    assign min        = (count_reg == '0);
    assign wrap_pulse = wrap_pulse_reg;

endmodule

// File: tb/tb_multi_speed_counter.sv
// Directed bench for multi_speed_counter. Two instances share every input:
// one saturating (_s) and one wrapping (_w). Each vector drives its pulses on
// edge number e (edges counted from the last reset edge = 0) and checks the
// outputs half a cycle later. Expected values are worked out by hand from a
// tick every 2^(4-speed) edges, i.e. on edges with e mod 2^(4-speed) == 0.
module tb_multi_speed_counter;

    logic clk = 1'b0;
    logic rst, en, dir, up, dn;

    logic [3:0] count_s, count_w;
    logic [1:0] speed_s, speed_w;
    logic       running_s, running_w, max_s, max_w, min_s, min_w, wrap_s, wrap_w;
    logic [3:0] dig_s, dig_w;
    logic [6:0] disp_s, disp_w;

    always #5 clk = ~clk;

    multi_speed_counter #(
        .MAX_COUNT(12), .N_SPEED(3), .BASE_DIV(4), .SCAN_DIV(2), .WRAP(0)
    ) dut_sat (
        .clk(clk), .rst(rst), .en_pulse(en), .dir(dir),
        .speed_up_pulse(up), .speed_down_pulse(dn),
        .count(count_s), .speed(speed_s), .running(running_s),
        .max(max_s), .min(min_s), .wrap_pulse(wrap_s),
        .DIGIT(dig_s), .DISPLAY(disp_s)
    );

    multi_speed_counter #(
        .MAX_COUNT(12), .N_SPEED(3), .BASE_DIV(4), .SCAN_DIV(2), .WRAP(1)
    ) dut_wrap (
        .clk(clk), .rst(rst), .en_pulse(en), .dir(dir),
        .speed_up_pulse(up), .speed_down_pulse(dn),
        .count(count_w), .speed(speed_w), .running(running_w),
        .max(max_w), .min(min_w), .wrap_pulse(wrap_w),
        .DIGIT(dig_w), .DISPLAY(disp_w)
    );

    typedef struct {
        int e;
        int rst, en, dir, up, dn;
        int c_s, c_w, spd, run, mx_s, mn_s, w_w;
        int chk, dig, disp;
    } vec_t;

    vec_t vq[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    task automatic check(input string name, input int idx, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s (vec %0d): got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        //          e  rst en dir up dn  c_s c_w spd run mx mn w_w chk dig      disp
        // Saturate / wrap at the top, speed 0 (tick every 16)
        vq.push_back('{  1, 0, 1, 0, 0, 0,  0,  0, 0, 1, 0, 1, 0, 0, 0, 0});
        vq.push_back('{ 15, 0, 0, 0, 0, 0,  0,  0, 0, 1, 0, 1, 0, 0, 0, 0});
        vq.push_back('{ 16, 0, 0, 0, 0, 0,  1,  1, 0, 1, 0, 0, 0, 0, 0, 0});
        vq.push_back('{ 32, 0, 0, 0, 0, 0,  2,  2, 0, 1, 0, 0, 0, 0, 0, 0});
        vq.push_back('{176, 0, 0, 0, 0, 0, 11, 11, 0, 1, 0, 0, 0, 0, 0, 0});
        vq.push_back('{192, 0, 0, 0, 0, 0, 12, 12, 0, 1, 1, 0, 0, 0, 0, 0});
        vq.push_back('{208, 0, 0, 0, 0, 0, 12,  0, 0, 1, 1, 0, 1, 0, 0, 0});
        vq.push_back('{209, 0, 0, 0, 0, 0, 12,  0, 0, 1, 1, 0, 0, 0, 0, 0});
        vq.push_back('{272, 0, 0, 0, 0, 0, 12,  4, 0, 1, 1, 0, 0, 0, 0, 0});
        // Count down, wrap at the bottom
        vq.push_back('{336, 0, 0, 1, 0, 0,  8,  0, 0, 1, 0, 0, 0, 0, 0, 0});
        vq.push_back('{352, 0, 0, 1, 0, 0,  7, 12, 0, 1, 0, 0, 1, 0, 0, 0});
        vq.push_back('{353, 0, 0, 1, 0, 0,  7, 12, 0, 1, 0, 0, 0, 0, 0, 0});
        // Speed up to saturation, period 4
        vq.push_back('{354, 0, 0, 1, 1, 0,  7, 12, 1, 1, 0, 0, 0, 0, 0, 0});
        vq.push_back('{355, 0, 0, 1, 1, 0,  7, 12, 2, 1, 0, 0, 0, 0, 0, 0});
        vq.push_back('{356, 0, 0, 1, 1, 0,  6, 11, 2, 1, 0, 0, 0, 0, 0, 0});
        vq.push_back('{360, 0, 0, 1, 0, 0,  5, 10, 2, 1, 0, 0, 0, 0, 0, 0});
        vq.push_back('{363, 0, 0, 1, 0, 0,  5, 10, 2, 1, 0, 0, 0, 0, 0, 0});
        vq.push_back('{364, 0, 0, 1, 0, 0,  4,  9, 2, 1, 0, 0, 0, 0, 0, 0});
        // Up and down together, then down to saturation
        vq.push_back('{365, 0, 0, 1, 1, 1,  4,  9, 2, 1, 0, 0, 0, 0, 0, 0});
        vq.push_back('{366, 0, 0, 1, 0, 1,  4,  9, 1, 1, 0, 0, 0, 0, 0, 0});
        vq.push_back('{367, 0, 0, 1, 0, 1,  4,  9, 0, 1, 0, 0, 0, 0, 0, 0});
        vq.push_back('{368, 0, 0, 1, 0, 1,  3,  8, 0, 1, 0, 0, 0, 0, 0, 0});
        // Pause on a tick edge: that tick still counts, then nothing for 64 cycles
        vq.push_back('{384, 0, 1, 1, 0, 0,  2,  7, 0, 0, 0, 0, 0, 0, 0, 0});
        vq.push_back('{448, 0, 0, 1, 0, 0,  2,  7, 0, 0, 0, 0, 0, 0, 0, 0});
        vq.push_back('{449, 0, 1, 1, 0, 0,  2,  7, 0, 1, 0, 0, 0, 0, 0, 0});
        vq.push_back('{464, 0, 0, 1, 0, 0,  1,  6, 0, 1, 0, 0, 0, 0, 0, 0});
        // Reach count 7 at speed 2 on the wrapping unit, then reset mid-count
        vq.push_back('{465, 0, 0, 1, 1, 0,  1,  6, 1, 1, 0, 0, 0, 0, 0, 0});
        vq.push_back('{466, 0, 0, 1, 1, 0,  1,  6, 2, 1, 0, 0, 0, 0, 0, 0});
        vq.push_back('{468, 0, 0, 1, 0, 0,  0,  5, 2, 1, 0, 1, 0, 0, 0, 0});
        vq.push_back('{476, 0, 0, 0, 0, 0,  2,  7, 2, 1, 0, 0, 0, 0, 0, 0});
        vq.push_back('{477, 1, 0, 0, 0, 0,  0,  0, 0, 0, 0, 1, 0, 1, 4'b1110, 7'b1000000});
        // After reset: wrap down to 12, then watch the scan at speed 1
        vq.push_back('{  1, 0, 1, 1, 0, 0,  0,  0, 0, 1, 0, 1, 0, 0, 0, 0});
        vq.push_back('{ 16, 0, 0, 1, 0, 0,  0, 12, 0, 1, 0, 1, 1, 0, 0, 0});
        vq.push_back('{ 20, 0, 0, 1, 0, 0,  0, 12, 0, 1, 0, 1, 0, 1, 4'b1101, 7'b1111001});
        vq.push_back('{ 24, 0, 0, 1, 0, 0,  0, 12, 0, 1, 0, 1, 0, 1, 4'b1011, 7'b1100011});
        vq.push_back('{ 25, 0, 0, 1, 1, 0,  0, 12, 1, 1, 0, 1, 0, 1, 4'b1011, 7'b1100011});
        vq.push_back('{ 28, 0, 0, 1, 0, 0,  0, 12, 1, 1, 0, 1, 0, 1, 4'b0111, 7'b1111001});
        vq.push_back('{ 32, 0, 0, 1, 0, 0,  0, 11, 1, 1, 0, 1, 0, 1, 4'b1110, 7'b0100100});

        // Power-up reset: the last edge with rst high is edge 0.
        rst = 1'b1; en = 1'b0; dir = 1'b0; up = 1'b0; dn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        @(negedge clk);
        check("reset_count",   -1, int'(count_w),   0);
        check("reset_speed",   -1, int'(speed_w),   0);
        check("reset_running", -1, int'(running_w), 0);
        check("reset_min",     -1, int'(min_w),     1);
        check("reset_max",     -1, int'(max_w),     0);
        check("reset_wrap",    -1, int'(wrap_w),    0);
        check("reset_digit",   -1, int'(dig_s),     4'b1110);
        check("reset_display", -1, int'(disp_s),    7'b1000000);
        $display("[TB] reset: count=%0d speed=%0d DIGIT=%b DISPLAY=%b", count_w, speed_w, dig_s, disp_s);

        foreach (vq[i]) begin
            dir = (vq[i].dir != 0);
            while (cyc < vq[i].e - 1) step();
            rst = (vq[i].rst != 0);
            en  = (vq[i].en  != 0);
            up  = (vq[i].up  != 0);
            dn  = (vq[i].dn  != 0);
            step();
            rst = 1'b0; en = 1'b0; up = 1'b0; dn = 1'b0;
            if (vq[i].rst != 0) cyc = 0;
            @(negedge clk);
            check("count_sat",   i, int'(count_s),   vq[i].c_s);
            check("count_wrap",  i, int'(count_w),   vq[i].c_w);
            check("speed_sat",   i, int'(speed_s),   vq[i].spd);
            check("speed_wrap",  i, int'(speed_w),   vq[i].spd);
            check("running_sat", i, int'(running_s), vq[i].run);
            check("running_wrap",i, int'(running_w), vq[i].run);
            check("max_sat",     i, int'(max_s),     vq[i].mx_s);
            check("min_sat",     i, int'(min_s),     vq[i].mn_s);
            check("wrap_pulse",  i, int'(wrap_w),    vq[i].w_w);
            check("no_wrap_sat", i, int'(wrap_s),    0);
            if (vq[i].chk != 0) begin
                check("digit",   i, int'(dig_w),  vq[i].dig);
                check("display", i, int'(disp_w), vq[i].disp);
            end
            $display("[TB] vec %0d e=%0d count=%0d/%0d speed=%0d run=%0d wrap=%0d DIGIT=%b DISPLAY=%b",
                     i, vq[i].e, count_s, count_w, speed_w, running_w, wrap_w, dig_w, disp_w);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
